// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM port between the ICache and the
// load/store buffer. Each word request is split into byte accesses, and the
// returned bytes are reassembled little-endian.
//   clk, rst (async, active-low), rdy (global ready; low freezes all state)
//   ram_din/ram_dout/ram_a/ram_wr    : byte-wide RAM/IO bus
//   io_buffer_full                   : defers stores that target the I/O window
//   IC_flag/IC_PC -> IC_commit/IC_val          : instruction fetch (4 bytes)
//   LSB_flag/wr/addr/len/data -> LSB_commit/val : load/store of 1, 2 or 4 bytes
//   ROB_jump_flag                    : aborts in-flight reads
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    input  logic              io_buffer_full,
    input  logic              IC_flag,
    input  logic [31:0]       IC_PC,
    output logic              IC_commit,
    output logic [31:0]       IC_val,
    input  logic              LSB_flag,
    input  logic              LSB_wr,
    input  logic [31:0]       LSB_addr,
    input  logic [1:0]        LSB_len,
    input  logic [31:0]       LSB_data,
    output logic              LSB_commit,
    output logic [31:0]       LSB_val,
    input  logic              ROB_jump_flag
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IC_RD = 2'd1;
    localparam logic [1:0] S_LS_RD = 2'd2;
    localparam logic [1:0] S_LS_WR = 2'd3;

    localparam logic G_IC  = 1'b0;
    localparam logic G_LSB = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     buf_q, buf_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ic_commit_q, ic_commit_d;
    logic [DW-1:0]     ic_val_q, ic_val_d;
    logic              lsb_commit_q, lsb_commit_d;
    logic [DW-1:0]     lsb_val_q, lsb_val_d;

    logic          ic_elig_c, lsb_elig_c, lsb_io_block_c;
    logic          grant_ic_c, grant_lsb_c;
    logic [CW-1:0] lsb_n_c;
    logic [DW-1:0] word_c;

    // Eligibility: a requester just served by last cycle's commit is skipped once.
    always_comb begin
        ic_elig_c      = IC_flag && !ic_commit_q;
        lsb_io_block_c = LSB_wr && (LSB_addr[17:16] == IO_SEL) && io_buffer_full;
        lsb_elig_c     = LSB_flag && !lsb_commit_q && !lsb_io_block_c;
        grant_ic_c     = ic_elig_c && (!lsb_elig_c || (last_q == G_LSB));
        grant_lsb_c    = lsb_elig_c && !grant_ic_c;
        case (LSB_len)
            2'b00:   lsb_n_c = CW'(1);
            2'b01:   lsb_n_c = CW'(2);
            default: lsb_n_c = CW'(4);
        endcase
    end

    // Final read word: captured lanes plus the last byte straight from ram_din.
    always_comb begin
        word_c = buf_q;
        for (int l = 0; l < 4; l++) begin
            if (CW'(l + 1) == n_q) word_c[8*l +: 8] = ram_din;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        last_d       = last_q;
        ram_a_d      = ram_a_q;
        ram_dout_d   = ram_dout_q;
        ram_wr_d     = ram_wr_q;
        ic_commit_d  = 1'b0;
        ic_val_d     = ic_val_q;
        lsb_commit_d = 1'b0;
        lsb_val_d    = lsb_val_q;

        case (state_q)
            S_IDLE: begin
                // The grant edge is also issue edge 0.
                if (!ROB_jump_flag) begin
                    if (grant_ic_c) begin
                        state_d  = S_IC_RD;
                        addr_d   = ADDR_W'(IC_PC);
                        n_d      = CW'(4);
                        cnt_d    = CW'(1);
                        buf_d    = '0;
                        last_d   = G_IC;
                        ram_a_d  = ADDR_W'(IC_PC);
                        ram_wr_d = 1'b0;
                    end else if (grant_lsb_c) begin
                        state_d  = LSB_wr ? S_LS_WR : S_LS_RD;
                        addr_d   = ADDR_W'(LSB_addr);
                        n_d      = lsb_n_c;
                        cnt_d    = CW'(1);
                        buf_d    = LSB_wr ? LSB_data : '0;
                        last_d   = G_LSB;
                        ram_a_d  = ADDR_W'(LSB_addr);
                        ram_wr_d = LSB_wr;
                        if (LSB_wr) ram_dout_d = LSB_data[7:0];
                    end
                end
            end

            S_IC_RD, S_LS_RD: begin
                if (ROB_jump_flag) begin
                    state_d = S_IDLE;
                    ram_a_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < n_q) ram_a_d = addr_q + ADDR_W'(cnt_q);
                    // Byte for issue k arrives one cycle later; captured at edge k+2.
                    for (int l = 0; l < 4; l++) begin
                        if (CW'(l + 2) == cnt_q) buf_d[8*l +: 8] = ram_din;
                    end
                    if (cnt_q == n_q + CW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        if (state_q == S_IC_RD) begin
                            ic_commit_d = 1'b1;
                            ic_val_d    = word_c;
                        end else begin
                            lsb_commit_d = 1'b1;
                            lsb_val_d    = word_c;
                        end
                    end
                end
            end

            S_LS_WR: begin
                // Stores are never aborted by a flush.
                if (cnt_q < n_q) begin
                    cnt_d   = cnt_q + CW'(1);
                    ram_a_d = addr_q + ADDR_W'(cnt_q);
                    for (int l = 0; l < 4; l++) begin
                        if (CW'(l) == cnt_q) ram_dout_d = buf_q[8*l +: 8];
                    end
                end else begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    ram_wr_d     = 1'b0;
                    ram_a_d      = '0;
                    lsb_commit_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; rdy low holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            last_q       <= G_IC;
            ram_a_q      <= '0;
            ram_dout_q   <= '0;
            ram_wr_q     <= 1'b0;
            ic_commit_q  <= 1'b0;
            ic_val_q     <= '0;
            lsb_commit_q <= 1'b0;
            lsb_val_q    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            last_q       <= last_d;
            ram_a_q      <= ram_a_d;
            ram_dout_q   <= ram_dout_d;
            ram_wr_q     <= ram_wr_d;
            ic_commit_q  <= ic_commit_d;
            ic_val_q     <= ic_val_d;
            lsb_commit_q <= lsb_commit_d;
            lsb_val_q    <= lsb_val_d;
        end
    end

    assign ram_a      = ram_a_q;
    assign ram_dout   = ram_dout_q;
    assign ram_wr     = ram_wr_q;
    assign IC_commit  = ic_commit_q;
    assign IC_val     = ic_val_q;
    assign LSB_commit = lsb_commit_q;
    assign LSB_val    = lsb_val_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single byte-wide RAM port and shares it between the instruction cache and the load/store buffer. Each word-level request is broken into byte accesses, and the bytes are reassembled little-endian. It arbitrates fairly between the two requesters, defers stores to the I/O window while the I/O buffer is full, and aborts speculative reads on a ROB jump. It sits between the ICache/LSB and the top-level RAM/IO bus.

## Interface
- ADDR_W, 32, width of byte addresses and ram_a.
- IO_SEL, 2'b11, value of addr[17:16] that marks the I/O window.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes every register.
- ram_din  in  8  read byte from RAM.
- ram_dout  out  8  write byte to RAM.
- ram_a  out  ADDR_W  byte address to RAM.
- ram_wr  out  1  1 = write cycle.
- io_buffer_full  in  1  I/O output buffer full.
- IC_flag  in  1  ICache fetch request, held until IC_commit.
- IC_PC  in  32  fetch address.
- IC_commit  out  1  one-cycle pulse; IC_val valid.
- IC_val  out  32  fetched word.
- LSB_flag  in  1  LSB request, held until LSB_commit.
- LSB_wr  in  1  1 = store, 0 = load.
- LSB_addr  in  32  byte address.
- LSB_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
- LSB_data  in  32  store data, low bytes used.
- LSB_commit  out  1  one-cycle pulse; load data valid or store done.
- LSB_val  out  32  load data, zero-extended.
- ROB_jump_flag  in  1  misprediction flush.

## Operation
- States:
  - IDLE, IC_RD, LS_RD, LS_WR.
  - Registers: latched addr, length n (1/2/4), issue counter, capture counter, byte buffer, last_grant.
- Grant (IDLE only):
  - Eligible IC: IC_flag=1 and IC was not served by the commit pulse of the previous cycle.
  - Eligible LSB: LSB_flag=1, not served by the previous commit, and not (LSB_wr=1 with LSB_addr[17:16]==IO_SEL while io_buffer_full=1).
  - One eligible requester: grant it.
  - Both eligible: grant the one not in last_grant. last_grant resets to IC, so the LSB wins the first tie.
  - IC always reads n=4.
- Read:
  - At issue edge k (k = 0..n-1), ram_a <= addr+k and ram_wr <= 0.
  - RAM returns the byte for the address presented during cycle k in ram_din during cycle k+1. That byte is captured at edge k+2 into byte lane k.
  - Final byte is taken directly from ram_din at edge n+1. At that edge commit <= 1, val <= assembled word (bits above 8n are zero), state <= IDLE.
- Write:
  - At edge k, ram_a <= addr+k, ram_wr <= 1, ram_dout <= LSB_data[8k+7:8k].
  - At edge n: ram_wr <= 0, ram_a <= 0, LSB_commit <= 1, state <= IDLE.
- Address arithmetic: addr+k is modulo 2^ADDR_W; wrap from 0xFFFFFFFF goes to 0.
- Flush (ROB_jump_flag=1 at an edge):
  - IC_RD and LS_RD abort: state <= IDLE, ram_a <= 0, no commit pulse, capture buffer discarded.
  - LS_WR is never aborted.
  - No grant occurs on a flush edge.
- rdy=0: all registers hold, including ram_wr, counters and commit pulses; nothing advances.
- Reset (rst=0, asynchronous):
  - State IDLE, last_grant=IC, counters 0.
  - Outputs: ram_a=0, ram_dout=0, ram_wr=0, IC_commit=0, IC_val=0, LSB_commit=0, LSB_val=0.
  - Reset mid-transaction discards the transaction.

## Timing
- Grant edge = E0.
- Read of n bytes: commit high in the cycle after E(n+1). IC fetch latency is 5 cycles from grant to commit.
- Write of n bytes: commit high in the cycle after En. A 4-byte store is 4 cycles.
- Commit pulses are exactly one cycle wide; val holds its value until the next commit.
- Next grant: earliest at the edge ending the commit cycle. The just-served requester is ignored at that edge; the other may be granted.
- ram_wr is high exactly n cycles per store, never during reads.
- I/O-deferred store: retried every IDLE edge until io_buffer_full=0. IC fetches proceed meanwhile.

## Test plan
- IC fetch: IC_PC=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 on E0..E3, IC_commit after E5, IC_val=0x00100513.
- Tie: IC_flag and LSB_flag (load, len=01, addr 0x200 = 0xAB,0xCD) rise together after reset -> LSB granted first, LSB_val=0x0000CDAB; IC granted next, with no idle edge between.
- Store word 0xDEADBEEF to 0x1FFFE -> ram_wr high 4 cycles, (ram_a, ram_dout) = (0x1FFFE,EF), (0x1FFFF,BE), (0x20000,AD), (0x20001,DE), LSB_commit after E4.
- I/O defer: store 1 byte to 0x30000 with io_buffer_full=1 for 10 cycles -> no ram_wr, a concurrent IC fetch completes, and the store issues on the first IDLE edge after full drops.
- Flush: ROB_jump_flag at E2 of an IC fetch -> no IC_commit, ram_a=0, idle next edge; a re-request at the new PC completes normally.
- Async reset during a store at E1, and rdy held low for 3 cycles mid-fetch -> all outputs 0 immediately on reset; the fetch with rdy low completes 3 cycles later with the correct value.
